// File: rtl/if_pkg.sv
// Shared constants and the buffered fetch-entry type for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; used for the pending-PC queue and the output buffer.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_count,
  output logic             o_empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != FULL_COUNT);
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: credit-limited in-order fetch, response buffering,
// IF/ID stall handling and redirect with stale-response dropping.
module instr_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        IF_IDWrite_i,
  output logic [31:0] PC_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        IF_flush_o
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_pend_count;
  logic [CW-1:0] w_buf_count;
  logic          w_pend_empty;
  logic          w_buf_empty;
  logic [31:0]   w_pend_head;
  logic [63:0]   w_buf_data;
  fetch_entry_t  w_buf_head;
  fetch_entry_t  w_buf_in;
  logic [CW:0]   w_occ;
  logic          w_issue;
  logic          w_capture;
  logic          w_pop;

  assign w_occ      = {1'b0, w_pend_count} + {1'b0, w_buf_count};
  assign imem_req_o = !rst_i && (w_occ < OCC_MAX) && !redirect_i && (r_drop == '0);
  assign imem_addr_o = r_fetch_pc;
  assign w_issue    = imem_req_o && imem_gnt_i;
  assign w_capture  = imem_rvalid_i && (r_drop == '0) && !redirect_i;
  assign w_pop      = valid_o && IF_IDWrite_i && !redirect_i;

  assign w_buf_in   = '{pc_plus4: w_pend_head + PC_STEP, instr: imem_rdata_i};
  assign w_buf_head = fetch_entry_t'(w_buf_data);

  assign valid_o    = !w_buf_empty;
  assign PC_o       = valid_o ? w_buf_head.pc_plus4 : '0;
  assign instr_o    = valid_o ? w_buf_head.instr : NOP_INSTR;
  assign IF_flush_o = redirect_i;

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pending (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_clear (redirect_i),
    .i_push  (w_issue),
    .i_data  (r_fetch_pc),
    .i_pop   (w_capture),
    .o_data  (w_pend_head),
    .o_count (w_pend_count),
    .o_empty (w_pend_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buffer (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_clear (redirect_i),
    .i_push  (w_capture),
    .i_data  (w_buf_in),
    .i_pop   (w_pop),
    .o_data  (w_buf_data),
    .o_count (w_buf_count),
    .o_empty (w_buf_empty)
  );

  // A redirect during an earlier drop window keeps the responses still owed to it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_drop     <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
      r_drop     <= r_drop + w_pend_count - CW'(imem_rvalid_i);
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (imem_rvalid_i && (r_drop != '0)) r_drop <= r_drop - 1'b1;
    end
  end

  a_no_orphan_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && w_pend_empty && (r_drop == '0)));

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage that drives the IF/ID pipeline register's producer side. It issues in-order requests to instruction memory and buffers returned words with their PCs. It presents one instruction per cycle on PC_o/instr_o and honours the downstream IF_IDWrite stall. On a branch/jump redirect it discards all in-flight and buffered fetches, restarts at the new PC, and raises IF_flush_o so IF/ID clears its instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, max fetches in flight plus buffered (power of two, ≥2)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (word aligned)
- imem_gnt_i  in  1  request accepted this cycle (req_o && gnt_i = issue)
- imem_rvalid_i  in  1  read data valid; responses in issue order, ≥1 cycle after issue
- imem_rdata_i  in  32  instruction word
- redirect_i  in  1  branch/jump taken, flush front end
- redirect_pc_i  in  32  new fetch address
- IF_IDWrite_i  in  1  IF/ID accepts PC_o/instr_o this cycle
- PC_o  out  32  fetch address + 4 of presented instruction
- instr_o  out  32  presented instruction; 32'h0 (NOP) when valid_o=0
- valid_o  out  1  PC_o/instr_o hold a real instruction
- IF_flush_o  out  1  clear IF/ID instruction this cycle

## Operation
- State: fetch_pc, pending-PC queue (PCs issued, response outstanding), output buffer of {pc+4, instr}, drop counter.
- Credit: occupancy = pending count + buffer count, registered. imem_req_o = (occupancy < DEPTH) && !redirect_i && drop==0. imem_addr_o = fetch_pc.
- Issue (req && gnt): push fetch_pc into pending queue; fetch_pc <= fetch_pc + 4 (32-bit wrap, 32'hFFFF_FFFC → 0).
- Response (rvalid, drop==0): pop pending PC p; push {p+4, rdata} into buffer.
- Output: valid_o = buffer non-empty; PC_o/instr_o = head, else PC_o=0, instr_o=0.
- Pop: valid_o && IF_IDWrite_i && !redirect_i. With IF_IDWrite_i=0, head held stable.
- Redirect (redirect_i=1): fetch_pc <= redirect_pc_i; buffer and pending queue cleared; drop <= pending count + (rvalid ? -1 : 0). A grant in this cycle cannot occur because req is low. IF_flush_o = redirect_i, combinational.
- Drop: while drop>0, each rvalid decrements drop, data discarded; no new requests until drop==0. This avoids misattribution of stale responses.
- Simultaneous: redirect beats pop, issue and response capture. Response + pop same cycle both apply; buffer cannot overflow because of the credit rule.
- rvalid with empty pending queue and drop==0 is illegal; assertion in sim.

## Timing
- Reset (async assert, sync release): fetch_pc=RESET_PC, queues empty, drop=0. Outputs: valid_o=0, instr_o=0, PC_o=0, imem_req_o=0 while rst_i=1, IF_flush_o=redirect_i.
- First cycle after release: imem_req_o=1, imem_addr_o=RESET_PC.
- Latency: issue cycle N, rvalid cycle N+L → valid_o in cycle N+L+1 (buffer registered, no bypass).
- Throughput: one instruction/cycle sustained when DEPTH ≥ L+2.
- Redirect in cycle R: IF_flush_o=1 in R; first request to redirect_pc_i in R+1 if no responses are outstanding, else the cycle after the last dropped rvalid.
- Reset mid-operation: all state discarded immediately. Memory must also be reset, so no stale rvalid follows.

## Structure
- Package if_pkg: NOP_INSTR=32'h0, PC_STEP=32'd4, default RESET_PC, typedef fetch_entry_t {pc_plus4[31:0], instr[31:0]}.
- Sub-module fetch_fifo (parameterised width/depth, sync FIFO with push/pop/clear, count output). Instantiated twice: pending-PC queue (32 bits) and output buffer (fetch_entry_t).

## Test plan
- Reset release, L=1, IF_IDWrite_i=1, mem returns addr as data → addresses 0,4,8… issued back-to-back; valid_o from cycle 3, PC_o=4,8,12…, instr_o=0,4,8…, one per cycle.
- Stall: IF_IDWrite_i=0 for 5 cycles after first valid → PC_o=4/instr_o=0 held; requests stop once occupancy=4; resume at addr 16 on release; no instruction lost or duplicated.
- Redirect to 32'h100 with 2 outstanding, L=3 → IF_flush_o=1 that cycle, valid_o=0 next; both stale responses dropped; next request addr 32'h100 after 2nd dropped rvalid; first valid PC_o=32'h104.
- Redirect coincident with rvalid and IF_IDWrite_i=1 → rvalid data discarded, no pop counted, drop = pending−1.
- Wrap: redirect to 32'hFFFF_FFFC → fetches FFFF_FFFC then 0; PC_o=0 then 4.
- Async reset asserted mid-burst → all outputs at reset values within the same cycle, restart at RESET_PC.
